bus_master: RTL and testbench

BUS_MASTER -- requirements
Module: bus_master

---
 rtl/bus_master.sv | 230 +++++++++++++++++++++++
 tb/tb_bus_master.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_master.sv
// Bus master for a single-cycle-at-a-time 68000-style asynchronous bus.
// Takes one command at a time, arbitrates for the bus (BR/BG/BGACK),
// runs the strobe sequence, waits for DTACK/BERR or a timeout, and
// returns a one-cycle response. Every output is a registered signal
// owned by the state machine. All bus signals are active-high; the
// pad level applies the inversion.

module bus_master #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        cpuclk_in,
    input  logic        reset_in,

    // Command channel
    input  logic        cmd_valid_in,
    output logic        cmd_ready,
    input  logic        cmd_wr_in,
    input  logic [23:0] cmd_addr_in,
    input  logic        cmd_uds_in,
    input  logic        cmd_lds_in,
    input  logic [15:0] cmd_wdata_in,

    // Response channel
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_berr,

    // Arbitration
    output logic        br,
    input  logic        bg_in,
    output logic        bgack,
    input  logic        bgack_in,

    // Bus observation and acknowledges
    input  logic        as_in,
    input  logic        dtack_in,
    input  logic        berr_in,

    // Driven bus signals
    output logic        as,
    output logic        uds,
    output logic        lds,
    output logic        wr,
    output logic [23:0] addr,
    output logic        addr_oe,
    output logic [15:0] data_out,
    output logic        data_oe,
    input  logic [15:0] data_in
);

    // The wait counter is 8 bits; a larger TIMEOUT clamps to the counter maximum.
    localparam logic [7:0] TimeoutCnt = (TIMEOUT > 255) ? 8'd255 : 8'(TIMEOUT);

    typedef enum logic [3:0] {
        StIdle,
        StReq,
        StAcq,
        StAddr,
        StStrb,
        StWds,
        StWait,
        StEnd,
        StRel
    } state_e;

    state_e      state_q;
    logic [7:0]  wait_cnt_q;

    // Command fields captured at accept time
    logic        lat_wr_q;
    logic [23:0] lat_addr_q;
    logic        lat_uds_q;
    logic        lat_lds_q;
    logic [15:0] lat_wdata_q;

    // Single state machine: sequences the bus cycle and registers every output.
    always_ff @(posedge cpuclk_in) begin
        if (reset_in) begin
            state_q     <= StIdle;
            wait_cnt_q  <= 8'd0;
            lat_wr_q    <= 1'b0;
            lat_addr_q  <= 24'd0;
            lat_uds_q   <= 1'b0;
            lat_lds_q   <= 1'b0;
            lat_wdata_q <= 16'd0;
            cmd_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= 16'd0;
            rsp_berr    <= 1'b0;
            br          <= 1'b0;
            bgack       <= 1'b0;
            as          <= 1'b0;
            uds         <= 1'b0;
            lds         <= 1'b0;
            wr          <= 1'b0;
            addr        <= 24'd0;
            addr_oe     <= 1'b0;
            data_out    <= 16'd0;
            data_oe     <= 1'b0;
        end else begin
            // Response strobe is a single-cycle pulse unless re-asserted below
            rsp_valid <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (cmd_valid_in) begin
                        lat_wr_q    <= cmd_wr_in;
                        // Word-aligned bus: byte-address bit 0 is dropped here
                        lat_addr_q  <= cmd_addr_in & 24'hFF_FFFE;
                        lat_uds_q   <= cmd_uds_in;
                        lat_lds_q   <= cmd_lds_in;
                        lat_wdata_q <= cmd_wdata_in;
                        if (!cmd_uds_in && !cmd_lds_in) begin
                            // No byte lane selected: fail without touching the bus
                            rsp_valid <= 1'b1;
                            rsp_berr  <= 1'b1;
                            rsp_rdata <= 16'd0;
                        end else begin
                            cmd_ready <= 1'b0;
                            br        <= 1'b1;
                            state_q   <= StReq;
                        end
                    end
                end

                StReq: begin
                    if (bg_in) begin
                        state_q <= StAcq;
                    end
                end

                StAcq: begin
                    // Previous owner has fully released the bus
                    if (!as_in && !dtack_in && !bgack_in) begin
                        bgack   <= 1'b1;
                        br      <= 1'b0;
                        addr_oe <= 1'b1;
                        addr    <= lat_addr_q;
                        wr      <= lat_wr_q;
                        data_oe <= lat_wr_q;
                        if (lat_wr_q) begin
                            data_out <= lat_wdata_q;
                        end
                        state_q <= StAddr;
                    end
                end

                StAddr: begin
                    as <= 1'b1;
                    // Reads assert the data strobes together with AS
                    if (!lat_wr_q) begin
                        uds <= lat_uds_q;
                        lds <= lat_lds_q;
                    end
                    state_q <= StStrb;
                end

                StStrb: begin
                    if (lat_wr_q) begin
                        state_q <= StWds;
                        uds     <= lat_uds_q;
                        lds     <= lat_lds_q;
                    end else begin
                        state_q    <= StWait;
                        wait_cnt_q <= 8'd0;
                    end
                end

                StWds: begin
                    state_q    <= StWait;
                    wait_cnt_q <= 8'd0;
                end

                StWait: begin
                    if (berr_in) begin
                        // BERR takes priority over a simultaneous DTACK
                        rsp_berr  <= 1'b1;
                        rsp_rdata <= 16'd0;
                        rsp_valid <= 1'b1;
                        as        <= 1'b0;
                        uds       <= 1'b0;
                        lds       <= 1'b0;
                        state_q   <= StEnd;
                    end else if (dtack_in) begin
                        rsp_berr  <= 1'b0;
                        rsp_rdata <= lat_wr_q ? 16'd0 : data_in;
                        rsp_valid <= 1'b1;
                        as        <= 1'b0;
                        uds       <= 1'b0;
                        lds       <= 1'b0;
                        state_q   <= StEnd;
                    end else if (wait_cnt_q == TimeoutCnt) begin
                        rsp_berr  <= 1'b1;
                        rsp_rdata <= 16'd0;
                        rsp_valid <= 1'b1;
                        as        <= 1'b0;
                        uds       <= 1'b0;
                        lds       <= 1'b0;
                        state_q   <= StEnd;
                    end else if (wait_cnt_q != 8'hFF) begin
                        // Saturate rather than wrap
                        wait_cnt_q <= wait_cnt_q + 8'd1;
                    end
                end

                StEnd: begin
                    addr_oe <= 1'b0;
                    data_oe <= 1'b0;
                    bgack   <= 1'b0;
                    state_q <= StRel;
                end

                StRel: begin
                    cmd_ready <= 1'b1;
                    state_q   <= StIdle;
                end

                default: begin
                    state_q   <= StIdle;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

    // Bus-ownership invariants: AS only while owning the bus, data driven only on writes.
    a_as_needs_bgack : assert property (@(posedge cpuclk_in) as |-> bgack);
    a_doe_write_only : assert property (@(posedge cpuclk_in) data_oe |-> wr);

endmodule

// File: tb/tb_bus_master.sv
// Directed self-checking bench for bus_master with hand-computed expectations.

module tb_bus_master;

    logic        cpuclk_in = 1'b0;
    logic        reset_in;
    logic        cmd_valid_in;
    logic        cmd_ready;
    logic        cmd_wr_in;
    logic [23:0] cmd_addr_in;
    logic        cmd_uds_in;
    logic        cmd_lds_in;
    logic [15:0] cmd_wdata_in;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_berr;
    logic        br;
    logic        bg_in;
    logic        bgack;
    logic        bgack_in;
    logic        as_in;
    logic        dtack_in;
    logic        berr_in;
    logic        as;
    logic        uds;
    logic        lds;
    logic        wr;
    logic [23:0] addr;
    logic        addr_oe;
    logic [15:0] data_out;
    logic        data_oe;
    logic [15:0] data_in;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses   = 0;
    int br_cnt   = 0;
    int viol_as  = 0;
    int viol_doe = 0;

    bus_master #(.TIMEOUT(255)) dut (
        .cpuclk_in    (cpuclk_in),
        .reset_in     (reset_in),
        .cmd_valid_in (cmd_valid_in),
        .cmd_ready    (cmd_ready),
        .cmd_wr_in    (cmd_wr_in),
        .cmd_addr_in  (cmd_addr_in),
        .cmd_uds_in   (cmd_uds_in),
        .cmd_lds_in   (cmd_lds_in),
        .cmd_wdata_in (cmd_wdata_in),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_berr     (rsp_berr),
        .br           (br),
        .bg_in        (bg_in),
        .bgack        (bgack),
        .bgack_in     (bgack_in),
        .as_in        (as_in),
        .dtack_in     (dtack_in),
        .berr_in      (berr_in),
        .as           (as),
        .uds          (uds),
        .lds          (lds),
        .wr           (wr),
        .addr         (addr),
        .addr_oe      (addr_oe),
        .data_out     (data_out),
        .data_oe      (data_oe),
        .data_in      (data_in)
    );

    always #5 cpuclk_in = ~cpuclk_in;

    // Monitors sample registered outputs on the falling edge
    always @(negedge cpuclk_in) begin
        if (rsp_valid) pulses++;
        if (br) br_cnt++;
        if (as && !bgack) viol_as++;
        if (data_oe && !wr) viol_doe++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // {br, bgack, addr_oe, data_oe, as, uds, lds, wr-on-bus, rsp_valid, cmd_ready}
    function automatic logic [9:0] ctl();
        return {br, bgack, addr_oe, data_oe, as, uds, lds, wr & addr_oe, rsp_valid, cmd_ready};
    endfunction

    task automatic step();
        @(negedge cpuclk_in);
    endtask

    // Present a command for one edge; returns at the first sample after acceptance
    task automatic offer(input logic w, input logic [23:0] a, input logic u, input logic l,
                         input logic [15:0] d);
        cmd_valid_in = 1'b1;
        cmd_wr_in    = w;
        cmd_addr_in  = a;
        cmd_uds_in   = u;
        cmd_lds_in   = l;
        cmd_wdata_in = d;
        step();
        cmd_valid_in = 1'b0;
    endtask

    // Complete read with DTACK answered in the first WAIT cycle
    task automatic quick_read(input logic [23:0] a, input logic [15:0] d);
        logic got;
        bg_in = 1'b1;
        offer(1'b0, a, 1'b1, 1'b1, 16'h0);
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (as) begin
                got = 1'b1;
                break;
            end
            step();
        end
        check_eq("qr_as_seen", 32'(got), 32'd1);
        dtack_in = 1'b1;
        data_in  = d;
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
        end
        check_eq("qr_rsp_seen", 32'(got), 32'd1);
        check_eq("qr_rdata", 32'(rsp_rdata), 32'(d));
        check_eq("qr_berr", 32'(rsp_berr), 32'd0);
        dtack_in = 1'b0;
        data_in  = 16'h0;
        step();
        step();
        check_eq("qr_idle", 32'(ctl()), 32'(10'b0000000001));
    endtask

    initial begin
        int n;
        int snap;
        reset_in     = 1'b1;
        cmd_valid_in = 1'b0;
        cmd_wr_in    = 1'b0;
        cmd_addr_in  = 24'h0;
        cmd_uds_in   = 1'b0;
        cmd_lds_in   = 1'b0;
        cmd_wdata_in = 16'h0;
        bg_in        = 1'b0;
        bgack_in     = 1'b0;
        as_in        = 1'b0;
        dtack_in     = 1'b0;
        berr_in      = 1'b0;
        data_in      = 16'h0;
        step();
        step();

        // Reset state
        check_eq("rst_ctl", 32'(ctl()), 32'(10'b0000000001));
        check_eq("rst_wr", 32'(wr), 32'd0);
        check_eq("rst_addr", 32'(addr), 32'd0);
        check_eq("rst_dout", 32'(data_out), 32'd0);
        check_eq("rst_rsp", 32'({rsp_rdata, rsp_berr}), 32'd0);
        reset_in = 1'b0;
        step();

        // Read 0x000400, grant after 3 cycles, DTACK in third WAIT cycle
        offer(1'b0, 24'h000400, 1'b1, 1'b1, 16'h0);
        for (int i = 0; i < 3; i++) begin
            check_eq("rd_req", 32'(ctl()), 32'(10'b1000000000));
            if (i == 2) bg_in = 1'b1;
            step();
        end
        check_eq("rd_acq", 32'(ctl()), 32'(10'b1000000000));
        step();
        check_eq("rd_addr_ctl", 32'(ctl()), 32'(10'b0110000000));
        check_eq("rd_addr", 32'(addr), 32'h000400);
        step();
        check_eq("rd_strb", 32'(ctl()), 32'(10'b0110111000));
        step();
        for (int i = 0; i < 3; i++) begin
            check_eq("rd_wait", 32'(ctl()), 32'(10'b0110111000));
            if (i == 2) begin
                dtack_in = 1'b1;
                data_in  = 16'hBEEF;
            end
            step();
        end
        check_eq("rd_end", 32'(ctl()), 32'(10'b0110000010));
        check_eq("rd_rdata", 32'(rsp_rdata), 32'hBEEF);
        check_eq("rd_berr", 32'(rsp_berr), 32'd0);
        dtack_in = 1'b0;
        data_in  = 16'h0;
        step();
        check_eq("rd_rel", 32'(ctl()), 32'(10'b0000000000));
        check_eq("rd_hold", 32'(rsp_rdata), 32'hBEEF);
        step();
        check_eq("rd_idle", 32'(ctl()), 32'(10'b0000000001));

        // Write 0x100002, LDS only, 0x00A5
        offer(1'b1, 24'h100002, 1'b0, 1'b1, 16'h00A5);
        check_eq("wr_req", 32'(ctl()), 32'(10'b1000000000));
        step();
        check_eq("wr_acq", 32'(ctl()), 32'(10'b1000000000));
        step();
        check_eq("wr_addr_ctl", 32'(ctl()), 32'(10'b0111000100));
        check_eq("wr_addr", 32'(addr), 32'h100002);
        check_eq("wr_dout", 32'(data_out), 32'h00A5);
        step();
        check_eq("wr_strb", 32'(ctl()), 32'(10'b0111100100));
        step();
        check_eq("wr_wds", 32'(ctl()), 32'(10'b0111101100));
        step();
        check_eq("wr_wait", 32'(ctl()), 32'(10'b0111101100));
        dtack_in = 1'b1;
        data_in  = 16'h1234;
        step();
        check_eq("wr_end", 32'(ctl()), 32'(10'b0111000110));
        check_eq("wr_rsp", 32'({rsp_rdata, rsp_berr}), 32'd0);
        dtack_in = 1'b0;
        data_in  = 16'h0;
        step();
        check_eq("wr_rel", 32'(ctl()), 32'(10'b0000000000));
        step();
        check_eq("wr_idle", 32'(ctl()), 32'(10'b0000000001));

        quick_read(24'h000200, 16'h1357);

        // Timeout: no acknowledge, TIMEOUT+1 = 256 WAIT cycles
        data_in = 16'hFFFF;
        offer(1'b0, 24'h000010, 1'b1, 1'b0, 16'h0);
        step();
        step();
        step();
        check_eq("to_strb", 32'(ctl()), 32'(10'b0110110000));
        n = 0;
        for (int k = 0; k < 400; k++) begin
            step();
            if (rsp_valid) break;
            n++;
        end
        check_eq("to_wait_cycles", 32'(n), 32'd256);
        check_eq("to_end", 32'(ctl()), 32'(10'b0110000010));
        check_eq("to_rdata", 32'(rsp_rdata), 32'd0);
        check_eq("to_berr", 32'(rsp_berr), 32'd1);
        data_in = 16'h0;
        step();
        step();
        check_eq("to_idle", 32'(ctl()), 32'(10'b0000000001));

        quick_read(24'h000202, 16'hC0DE);

        // Bus still busy during ACQ, then DTACK and BERR together
        as_in = 1'b1;
        offer(1'b0, 24'h000020, 1'b1, 1'b0, 16'h0);
        check_eq("dual_req", 32'(ctl()), 32'(10'b1000000000));
        step();
        for (int i = 0; i < 3; i++) begin
            check_eq("dual_acq_hold", 32'(ctl()), 32'(10'b1000000000));
            if (i == 1) begin
                as_in    = 1'b0;
                bgack_in = 1'b1;
            end
            if (i == 2) bgack_in = 1'b0;
            step();
        end
        check_eq("dual_addr", 32'(ctl()), 32'(10'b0110000000));
        step();
        check_eq("dual_strb", 32'(ctl()), 32'(10'b0110110000));
        step();
        dtack_in = 1'b1;
        berr_in  = 1'b1;
        data_in  = 16'h5555;
        step();
        check_eq("dual_end", 32'(ctl()), 32'(10'b0110000010));
        check_eq("dual_berr", 32'(rsp_berr), 32'd1);
        check_eq("dual_rdata", 32'(rsp_rdata), 32'd0);
        dtack_in = 1'b0;
        berr_in  = 1'b0;
        data_in  = 16'h0;
        step();
        step();

        quick_read(24'h000204, 16'hA1A1);

        // No byte lanes: immediate error, no bus request
        br_cnt = 0;
        offer(1'b0, 24'h000300, 1'b0, 1'b0, 16'h0);
        check_eq("null_rsp", 32'(ctl()), 32'(10'b0000000011));
        check_eq("null_berr", 32'(rsp_berr), 32'd1);
        check_eq("null_rdata", 32'(rsp_rdata), 32'd0);
        step();
        check_eq("null_after", 32'(ctl()), 32'(10'b0000000001));
        check_eq("null_berr_hold", 32'(rsp_berr), 32'd1);
        step();
        check_eq("null_no_br", 32'(br_cnt), 32'd0);

        // Reset during WAIT
        offer(1'b0, 24'h000500, 1'b1, 1'b1, 16'h0);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            if (as) break;
            step();
            n++;
        end
        check_eq("rst_mid_as_seen", 32'(as), 32'd1);
        step();
        step();
        check_eq("rst_mid_wait", 32'(ctl()), 32'(10'b0110111000));
        reset_in = 1'b1;
        snap = pulses;
        step();
        check_eq("rst_mid_ctl", 32'(ctl()), 32'(10'b0000000001));
        check_eq("rst_mid_addr", 32'(addr), 32'd0);
        check_eq("rst_mid_dout", 32'(data_out), 32'd0);
        check_eq("rst_mid_rsp", 32'({rsp_rdata, rsp_berr}), 32'd0);
        reset_in = 1'b0;
        repeat (5) step();
        check_eq("rst_mid_no_rsp", 32'(pulses), 32'(snap));
        check_eq("rst_mid_idle", 32'(ctl()), 32'(10'b0000000001));

        // read, write, 3 quick reads, timeout, dual-ack, null
        check_eq("pulse_total", 32'(pulses), 32'd8);
        check_eq("inv_as_bgack", 32'(viol_as), 32'd0);
        check_eq("inv_doe_read", 32'(viol_doe), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
